fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage with IF/ID pipeline register, directly upstream of control_unit.
//  Holds the PC and fetches words over a valid/ready instruction-memory port.
//  Presents the fetched instruction, its PC and opcode (instr[6:0]) to decode/control_unit.
//  Honours hazard stalls and branch/jump redirects, and absorbs memory wait states.
// PARAMETERS
//  XLEN       32             address/data width
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0013  addi x0,x0,0; driven on if_instr whenever the slot is invalid
// PORTS
//  clk             in   1     single clock, rising edge
//  rst             in   1     synchronous, active-high reset
//  stall           in   1     hazard unit: hold IF/ID contents
//  redirect_valid  in   1     taken branch/JAL/JALR; flush and reload PC
//  redirect_pc     in   XLEN  redirect target; bits [1:0] ignored (treated as 0)
//  imem_req        out  1     request valid
//  imem_addr       out  XLEN  word address, always 4-byte aligned
//  imem_ready      in   1     transfer completes when imem_req && imem_ready
//  imem_rdata      in   32    instruction word; valid in the transfer cycle
//  if_valid        out  1     IF/ID slot holds a real instruction
//  if_pc           out  XLEN  PC of if_instr
//  if_instr        out  32    instruction, or NOP_INSTR when !if_valid
//  opcode          out  7     if_instr[6:0]; feeds control_unit
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_IDLE, imem_req=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR,
//   opcode=7'b0010011, skid buffer empty. Reset mid-transfer abandons it, with no wait.
//  FSM states:
//   S_IDLE   one cycle after reset -> S_FETCH.
//   S_FETCH  imem_req=1 with imem_addr=pc, unless skid full; on transfer pc<=pc+4 (mod 2^XLEN).
//   S_DRAIN  redirect arrived mid-request: keep req/addr, discard data on transfer,
//            then pc<=saved target -> S_FETCH.
//  Protocol: once imem_req is asserted, imem_req and imem_addr stay stable until imem_ready.
//  Latency: word transferred in cycle N appears on if_* in cycle N+1 (0 wait states = 1 instr/cycle).
//  Stall, when stall && if_valid:
//   - IF/ID holds.
//   - A transfer completing during the stall goes into a 1-entry skid (word + PC).
//   - No new request is issued while the skid is full.
//   - When stall drops, skid -> IF/ID and the skid empties; order is preserved, with no loss or duplication.
//  If stall is high and if_valid=0, the slot loads normally.
//  Redirect has priority over stall and over transfer in the same cycle:
//   - Next cycle: if_valid=0, skid empty.
//   - No request outstanding, or request completing this cycle: data discarded,
//     pc<=redirect_pc&~3, next req at the target.
//   - Request outstanding and not ready: save target -> S_DRAIN.
//   - A second redirect during S_DRAIN overwrites the saved target.
//  pc wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
// STRUCTURE
//  riscv_pkg: OPC_RTYPE/OPC_ITYPE/OPC_LOAD/OPC_STORE/OPC_BRANCH/OPC_JAL/OPC_JALR
//   constants, NOP_INSTR, fetch_state_t {S_IDLE,S_FETCH,S_DRAIN}.
//  Sub-module fetch_skid_buf: 1-entry {pc,instr} buffer with load/unload/flush.
// TESTING
//  1 Reset: rst=1 two cycles -> imem_req=0, if_valid=0, if_instr=0x00000013, opcode=0010011;
//    after release, S_IDLE cycle, then imem_req=1, imem_addr=0x0.
//  2 Streaming, imem_ready=1, rdata=0x00000033 -> if_pc 0x0,0x4,0x8 on consecutive cycles,
//    opcode=0110011.
//  3 Wait states: ready low 3 cycles on addr 0x4 -> addr held 0x4 for 4 cycles,
//    exactly one word delivered, if_pc=0x4.
//  4 Stall 3 cycles with a transfer landing mid-stall -> if_instr frozen, skid full, imem_req=0;
//    after release the PC sequence continues gap-free, with no duplicates.
//  5 Redirect 0x100 while waiting on 0x8 -> 0x8 response discarded, next imem_addr=0x100,
//    first valid if_pc=0x100.
//  6 redirect+stall same cycle -> if_valid=0 next cycle; redirect_pc=0x103 fetches 0x100;
//    pc 0xFFFFFFFC increments to 0x0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch/decode definitions: opcode constants, the canonical NOP and
// the fetch FSM state encoding.
// Ports: none (package).
package riscv_pkg;

   // Major opcodes (instr[6:0]) consumed by control_unit.
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // addi x0,x0,0 -- shown downstream whenever the IF/ID slot is empty.
   localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OPC_ITYPE};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory valid/ready port
// and the IF/ID outputs towards decode.
// Ports: master = fetch_unit side, slave = environment (hazard unit, imem, decode).
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;

   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic [6:0]      opcode;

   modport master (
      input  stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
      output imem_req, imem_addr, if_valid, if_pc, if_instr, opcode
   );

   modport slave (
      output stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
      input  imem_req, imem_addr, if_valid, if_pc, if_instr, opcode
   );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer that catches a word landing while IF/ID is stalled.
// Ports: clk_i/rst_i; load_i/unload_i/flush_i controls (flush wins, then load);
//        pc_i/instr_i write data; full_o, pc_o, instr_o registered contents.
module fetch_skid_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            unload_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   output logic            full_o,
   output logic [XLEN-1:0] pc_o,
   output logic [31:0]     instr_o
);

   logic            full_q,  full_d;
   logic [XLEN-1:0] pc_q,    pc_d;
   logic [31:0]     instr_q, instr_d;

   always_comb begin
      full_d  = full_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (flush_i) begin
         full_d = 1'b0;
      end else if (load_i) begin
         full_d  = 1'b1;
         pc_d    = pc_i;
         instr_d = instr_i;
      end else if (unload_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q  <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         full_q  <= full_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign full_o  = full_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register: PC, valid/ready imem port, stall skid, redirects.
// Ports: clk, rst (sync, active high); bus (fetch_unit_if.master) carrying stall/redirect,
//        imem_req/addr/ready/rdata and if_valid/if_pc/if_instr/opcode. Fetch-to-IF/ID latency 1.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_WORD  = NOP_INSTR
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   fetch_state_t    state_q,    state_d;
   logic [XLEN-1:0] pc_q,       pc_d;
   logic [XLEN-1:0] tgt_q,      tgt_d;
   logic            req_q,      req_d;
   logic            vld_q,      vld_d;
   logic [XLEN-1:0] ipc_q,      ipc_d;
   logic [31:0]     instr_q,    instr_d;

   logic            xfer;
   logic            hold;
   logic [XLEN-1:0] redir_tgt;
   logic            skid_load, skid_unload, skid_flush;
   logic            skid_full, skid_full_d;
   logic [XLEN-1:0] skid_pc;
   logic [31:0]     skid_instr;

   assign xfer      = req_q && bus.imem_ready;
   assign hold      = bus.stall && vld_q;
   assign redir_tgt = bus.redirect_pc & ALIGN_MASK;

   fetch_skid_buf #(.XLEN(XLEN)) u_skid (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .flush_i  (skid_flush),
      .pc_i     (pc_q),
      .instr_i  (bus.imem_rdata),
      .full_o   (skid_full),
      .pc_o     (skid_pc),
      .instr_o  (skid_instr)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      tgt_d       = tgt_q;
      vld_d       = vld_q;
      ipc_d       = ipc_q;
      instr_d     = instr_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_flush  = 1'b0;

      if (bus.redirect_valid) begin
         // Redirect beats both stall and any transfer this cycle.
         vld_d      = 1'b0;
         instr_d    = NOP_WORD;
         skid_flush = 1'b1;
         if (state_q == S_DRAIN) begin
            if (xfer) begin
               pc_d    = redir_tgt;
               state_d = S_FETCH;
            end else begin
               tgt_d = redir_tgt;
            end
         end else if (req_q && !bus.imem_ready) begin
            // Request must stay stable until accepted: park the target and drain.
            tgt_d   = redir_tgt;
            state_d = S_DRAIN;
         end else begin
            pc_d    = redir_tgt;
            state_d = S_FETCH;
         end
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_DRAIN: begin
               if (xfer) begin
                  pc_d    = tgt_q;
                  state_d = S_FETCH;
               end
            end
            default: begin
               if (xfer) pc_d = pc_q + XLEN'(4);
            end
         endcase

         if (hold) begin
            // Slot frozen; a word landing now is parked. The skid is empty here
            // because no request is issued while it is full.
            if (xfer && state_q == S_FETCH) skid_load = 1'b1;
         end else if (skid_full) begin
            vld_d       = 1'b1;
            ipc_d       = skid_pc;
            instr_d     = skid_instr;
            skid_unload = 1'b1;
         end else if (xfer && state_q == S_FETCH) begin
            vld_d   = 1'b1;
            ipc_d   = pc_q;
            instr_d = bus.imem_rdata;
         end else begin
            vld_d   = 1'b0;
            instr_d = NOP_WORD;
         end
      end

      skid_full_d = skid_flush ? 1'b0 :
                    skid_load  ? 1'b1 :
                    skid_unload ? 1'b0 : skid_full;

      // Registered request, derived from the next state so it never drops mid-transfer.
      req_d = (state_d == S_DRAIN) || ((state_d == S_FETCH) && !skid_full_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
         req_q   <= 1'b0;
         vld_q   <= 1'b0;
         ipc_q   <= '0;
         instr_q <= NOP_WORD;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         req_q   <= req_d;
         vld_q   <= vld_d;
         ipc_q   <= ipc_d;
         instr_q <= instr_d;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = pc_q;
   assign bus.if_valid  = vld_q;
   assign bus.if_pc     = ipc_q;
   assign bus.if_instr  = vld_q ? instr_q : NOP_WORD;
   assign bus.opcode    = bus.if_instr[6:0];

endmodule
